fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Consumer of the branch unit's next-PC: holds the architectural fetch PC and issues
//   word fetches to instruction memory over a valid/ready request channel. Buffers
//   in-order responses for decode and kills stale fetches when a branch/jump redirects.
//   Sits between the branch unit (redirect source), the imem port and the decoder.
// PARAMETERS
//   RESET_PC  32'h0000_0000  fetch PC loaded on reset
//   BUF_DEPTH 2              instruction buffer entries, also max in-flight credit (>=1)
// PORTS
//   clk             in   1   clock, rising edge
//   rst             in   1   reset, asynchronous, active-high
//   redirect_valid  in   1   taken branch/jump this cycle
//   redirect_pc     in   32  redirect target (branch unit new_pc)
//   imem_req_valid  out  1   fetch request valid
//   imem_req_ready  in   1   imem accepts request
//   imem_req_addr   out  32  fetch word address (= fetch_pc)
//   imem_rsp_valid  in   1   in-order response valid, always accepted
//   imem_rsp_data   in   32  fetched instruction
//   inst_valid      out  1   buffer head valid to decode
//   inst_ready      in   1   decode accepts head
//   inst_data       out  32  head instruction
//   inst_pc         out  32  head instruction PC
//   misaligned_err  out  1   sticky: redirect target not word aligned
// BEHAVIOUR
// - Reset (async, any cycle): fetch_pc=RESET_PC; outstanding, drop_cnt, buffer count=0;
//   imem_req_valid=0, inst_valid=0, misaligned_err=0. In-flight state discarded.
// - imem_req_valid = !misaligned_err && (outstanding + count < BUF_DEPTH) (credit:
//   every response always has a buffer slot). First request the cycle after rst low.
// - req_fire (valid&ready): fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0), outstanding++;
//   fire PC pushed to in-flight PC queue (depth BUF_DEPTH) to tag the response.
// - Address held until ready; only a redirect may change it (memory tolerates this).
// - imem_rsp_valid: outstanding--, pop PC queue. drop_cnt>0 -> drop_cnt--, discard;
//   else push {pc,data} into buffer. rsp with outstanding==0 is illegal (assert).
// - Buffer: FIFO, registered; rsp-to-inst_valid latency 1 cycle. pop on inst_valid &
//   inst_ready. Simultaneous push and pop legal; count unchanged.
// - redirect_valid (has priority over everything except reset):
//     aligned: fetch_pc<=redirect_pc, misaligned_err<=0, next-cycle req_addr=redirect_pc.
//     redirect_pc[1:0]!=0: misaligned_err<=1, fetch_pc<=redirect_pc, requests stop
//     until an aligned redirect or reset.
//   Both: buffer flushed (count<=0, same-cycle pop ignored); same-cycle rsp discarded;
//   drop_cnt <= outstanding + req_fire - rsp_valid (all in-flight fetches killed,
//   including one accepted in the redirect cycle); outstanding updated normally.
// - Back-to-back redirects: each recomputes drop_cnt from the current outstanding.
// - Halted (misaligned_err): stale responses still drained/dropped; inst_valid stays 0.
// TESTING
// - Reset, imem always ready, 1-cycle rsp, decode ready -> addrs 0,4,8,..; inst_pc
//   0,4,8 in order, inst_data matches mem[pc>>2].
// - inst_ready=0 -> after 2 fetches req_valid=0, buffer full; ready=1 -> drains in
//   order, fetch resumes, no loss/dup.
// - 2 fetches in flight, redirect to 0x100 -> both responses dropped, next inst_pc=0x100.
// - Redirect to 0x102 -> misaligned_err=1, req_valid=0; redirect 0x200 -> err=0,
//   fetch 0x200.
// - Redirect with rsp_valid and inst pop same cycle -> buffer empty next cycle,
//   drop_cnt correct; rst mid-stream -> req_addr=RESET_PC, inst_valid=0.
// - Redirect to 0xFFFF_FFFC -> next fetches 0xFFFF_FFFC then 0x0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues credit-limited word fetches and
// buffers in-order responses for decode; a redirect kills every fetch still in flight.

module fetch_unit_chk #(
  parameter int CW = 2
) (
  input logic          clk,
  input logic          rst,
  input logic          rsp_valid,
  input logic [CW-1:0] outstanding
);
  // A response can only answer an accepted, still-outstanding request.
  rsp_has_request: assert property (@(posedge clk) disable iff (rst)
    rsp_valid |-> (outstanding != {CW{1'b0}}));
endmodule

module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        misaligned_err
);
  localparam int            CW       = $clog2(BUF_DEPTH + 1);
  localparam int            PW       = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(BUF_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(BUF_DEPTH - 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          misaligned_q, misaligned_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
  logic [PW-1:0] buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
  logic [31:0]   pcq_q      [BUF_DEPTH];
  logic [31:0]   buf_pc_q   [BUF_DEPTH];
  logic [31:0]   buf_data_q [BUF_DEPTH];
  logic          req_fire, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Credit: outstanding fetches plus buffered entries never exceed the buffer depth.
  assign imem_req_valid = !rst && !misaligned_q &&
                          (({1'b0, outstanding_q} + {1'b0, count_q}) < DEPTH_W);
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign imem_req_addr  = fetch_pc_q;
  assign misaligned_err = misaligned_q;
  assign inst_valid     = (count_q != {CW{1'b0}});
  assign inst_data      = buf_data_q[buf_rd_q];
  assign inst_pc        = buf_pc_q[buf_rd_q];

  // Next-state: fetch PC, credit counters, kill count and both FIFO pointers.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    misaligned_d  = misaligned_q;
    drop_d        = drop_q;
    count_d       = count_q;
    buf_wr_d      = buf_wr_q;
    buf_rd_d      = buf_rd_q;
    push          = 1'b0;
    pop           = 1'b0;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
    pcq_wr_d      = req_fire ? ptr_inc(pcq_wr_q) : pcq_wr_q;
    pcq_rd_d      = imem_rsp_valid ? ptr_inc(pcq_rd_q) : pcq_rd_q;
    if (redirect_valid) begin
      // Everything still in flight after this edge, including a same-cycle fire, is stale.
      fetch_pc_d   = redirect_pc;
      misaligned_d = (redirect_pc[1:0] != 2'b00);
      drop_d       = outstanding_d;
      count_d      = {CW{1'b0}};
      buf_wr_d     = {PW{1'b0}};
      buf_rd_d     = {PW{1'b0}};
    end else begin
      fetch_pc_d = req_fire ? (fetch_pc_q + 32'd4) : fetch_pc_q;
      if (imem_rsp_valid && (drop_q != {CW{1'b0}})) begin
        drop_d = drop_q - CW'(1);
      end else begin
        drop_d = drop_q;
      end
      push     = imem_rsp_valid && (drop_q == {CW{1'b0}});
      pop      = inst_valid && inst_ready;
      count_d  = count_q + CW'(push) - CW'(pop);
      buf_wr_d = push ? ptr_inc(buf_wr_q) : buf_wr_q;
      buf_rd_d = pop ? ptr_inc(buf_rd_q) : buf_rd_q;
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      misaligned_q  <= 1'b0;
      outstanding_q <= {CW{1'b0}};
      drop_q        <= {CW{1'b0}};
      count_q       <= {CW{1'b0}};
      pcq_wr_q      <= {PW{1'b0}};
      pcq_rd_q      <= {PW{1'b0}};
      buf_wr_q      <= {PW{1'b0}};
      buf_rd_q      <= {PW{1'b0}};
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      misaligned_q  <= misaligned_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      pcq_wr_q      <= pcq_wr_d;
      pcq_rd_q      <= pcq_rd_d;
      buf_wr_q      <= buf_wr_d;
      buf_rd_q      <= buf_rd_d;
    end
  end

  // Payload storage; validity is tracked by the pointers and count above.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pcq_q[pcq_wr_q] <= fetch_pc_q;
    end
    if (push) begin
      buf_pc_q[buf_wr_q]   <= pcq_q[pcq_rd_q];
      buf_data_q[buf_wr_q] <= imem_rsp_data;
    end
  end

  fetch_unit_chk #(.CW(CW)) u_chk (
    .clk         (clk),
    .rst         (rst),
    .rsp_valid   (imem_rsp_valid),
    .outstanding (outstanding_q)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based model of the fetch pipeline
// (in-flight fetches tagged killed on redirect, decode buffer as a plain queue).

module tb_fetch_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        misaligned_err;

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .misaligned_err (misaligned_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] pc; logic killed;} inf_t;
  typedef struct packed {logic [31:0] pc; logic [31:0] data;} ent_t;

  inf_t        m_inf[$];
  ent_t        m_buf[$];
  logic [31:0] m_dlv[$];
  logic [31:0] m_pc = 32'h0;
  logic        m_err = 1'b0;
  int          tests = 0;
  int          fails = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic m_req();
    return !rst && !m_err && ((m_inf.size() + m_buf.size()) < DEPTH);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  // One cycle: drive inputs just after the falling edge and advance the model past the next rising edge.
  task automatic step(input logic red, input logic [31:0] rpc, input logic rdy,
                      input logic rsp_en, input logic irdy, input logic rs);
    logic fire, rv, pop, push;
    inf_t h;
    ent_t e;
    @(negedge clk);
    #1;
    rst = rs;
    if (rs) begin
      redirect_valid = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; inst_ready = 1'b0;
      m_inf.delete(); m_buf.delete(); m_pc = 32'h0; m_err = 1'b0;
      return;
    end
    fire = m_req() && rdy;
    rv   = rsp_en && (m_inf.size() != 0);
    pop  = (m_buf.size() != 0) && irdy;
    redirect_valid = red;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    imem_rsp_valid = rv;
    imem_rsp_data  = rv ? memf(m_inf[0].pc) : $urandom;
    inst_ready     = irdy;
    push = 1'b0;
    e    = '0;
    if (rv) begin
      h    = m_inf.pop_front();
      push = !h.killed && !red;
      e    = '{h.pc, imem_rsp_data};
    end
    if (pop && !red) begin
      m_dlv.push_back(m_buf[0].pc);
      void'(m_buf.pop_front());
    end
    if (push) m_buf.push_back(e);
    if (fire) begin
      m_inf.push_back('{m_pc, 1'b0});
      m_pc = m_pc + 32'd4;
    end
    if (red) begin
      foreach (m_inf[i]) m_inf[i].killed = 1'b1;
      m_buf.delete();
      m_pc  = rpc;
      m_err = (rpc[1:0] != 2'b00);
    end
  endtask

  task automatic drain_to(input int n, input string nm);
    int k = 0;
    while (m_dlv.size() < n && k < 40) begin
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
      k++;
    end
    tests++;
    if (m_dlv.size() < n) begin
      fails++;
      $display("FAIL %s timeout delivered=%0d needed=%0d", nm, m_dlv.size(), n);
    end
  endtask

  // Every falling edge: DUT outputs must equal the model's view of the state.
  always @(negedge clk) begin
    chk("req_valid", 32'(imem_req_valid), 32'(m_req()));
    chk("req_addr", imem_req_addr, m_pc);
    chk("misaligned_err", 32'(misaligned_err), 32'(m_err));
    chk("inst_valid", 32'(inst_valid), 32'(m_buf.size() != 0));
    if (m_buf.size() != 0) begin
      chk("inst_pc", inst_pc, m_buf[0].pc);
      chk("inst_data", inst_data, m_buf[0].data);
    end
  end

  initial begin
    int k;
    logic [31:0] rpc;
    #1 rst = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("pin_reset_pc", m_pc, 32'h0);

    // Free-running fetch: 0,4,8 in order.
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("pin_seq0", m_dlv[0], 32'h0);
    chk("pin_seq1", m_dlv[1], 32'h4);
    chk("pin_seq2", m_dlv[2], 32'h8);

    // Decode stalled: buffer fills, requests stop; then drain with no loss/dup.
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("pin_buf_full", 32'(m_buf.size()), 32'(DEPTH));
    chk("pin_stall_noreq", 32'(m_req()), 32'h0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i + 1 < m_dlv.size(); i++)
      chk("pin_inorder", m_dlv[i + 1], m_dlv[i] + 32'd4);

    // Two fetches in flight, redirect to 0x100.
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("pin_two_inflight", 32'(m_inf.size()), 32'd2);
    step(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 1'b0);
    k = m_dlv.size();
    drain_to(k + 1, "redir_100");
    if (m_dlv.size() > k) chk("pin_redir_100", m_dlv[k], 32'h100);

    // Misaligned redirect halts; aligned redirect resumes.
    step(1'b1, 32'h102, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("pin_misaligned", 32'(m_err), 32'h1);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h200, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("pin_err_clear", 32'(m_err), 32'h0);
    k = m_dlv.size();
    drain_to(k + 1, "redir_200");
    if (m_dlv.size() > k) chk("pin_redir_200", m_dlv[k], 32'h200);

    // Redirect with a response and a decode pop in the same cycle.
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("pin_pre_buf", 32'(m_buf.size()), 32'd1);
    chk("pin_pre_inf", 32'(m_inf.size()), 32'd1);
    step(1'b1, 32'h300, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("pin_flush", 32'(m_buf.size()), 32'd0);
    k = m_dlv.size();
    drain_to(k + 1, "redir_300");
    if (m_dlv.size() > k) chk("pin_redir_300", m_dlv[k], 32'h300);

    // Reset in the middle of traffic.
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("pin_midrst_pc", m_pc, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);

    // Wrap at the top of the address space.
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1, 1'b0);
    k = m_dlv.size();
    drain_to(k + 2, "wrap");
    if (m_dlv.size() > k + 1) begin
      chk("pin_wrap0", m_dlv[k], 32'hFFFF_FFFC);
      chk("pin_wrap1", m_dlv[k + 1], 32'h0);
    end

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rpc = {$urandom, 2'b00} | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      step(($urandom_range(0, 15) == 0), rpc, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 399) == 0));
    end
    step(1'b1, 32'h40, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
